bit_serializer: RTL

Parallel-to-serial feeder for the serial sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `ser_out`, which drives the detector's serial `in` input. A one-word holding buffer lets consecutive words stream with no idle gap, so patterns that span a word boundary reach the detector unbroken.

---
 rtl/bit_serializer.sv | 94 +++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with a one-word holding buffer so words stream gap-free.
// Build option: define SER_LSB_FIRST_EN for LSB-first output (MSB-first otherwise).
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_hbuf;
    logic [CW-1:0]    r_cnt;
    logic             r_hfull;

    logic             w_accept;
    logic             w_last;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shifted;

`ifdef SER_LSB_FIRST_EN
    assign w_out_bit = r_shreg[0];
    assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
`else
    assign w_out_bit = r_shreg[WIDTH-1];
    assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
`endif

    // Outputs decode straight from registers so the async reset clears them at once.
    assign ser_valid  = (r_state == SHIFT);
    assign w_last     = ser_valid && (r_cnt == LAST);
    assign ser_out    = ser_valid && w_out_bit;
    assign word_done  = w_last;
    assign load_ready = !r_hfull;
    assign w_accept   = load_valid && load_ready;
    assign busy       = ser_valid || r_hfull;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_hbuf  <= '0;
            r_cnt   <= '0;
            r_hfull <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg <= load_data;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!w_last) begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_accept) begin
                            r_hbuf  <= load_data;
                            r_hfull <= 1'b1;
                        end
                    end else if (r_hfull) begin
                        r_shreg <= r_hbuf;
                        r_hfull <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        // Last-bit accept bypasses the buffer to keep the stream gap-free.
                        r_shreg <= load_data;
                        r_cnt   <= '0;
                    end else begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
